// File: rtl/pipe_acc_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_acc_adder_if
//  Purpose  : Operand/result stream bundle for pipe_acc_adder.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_acc_adder_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic             mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic [CNT_W-1:0] acc_cnt;

    modport master (
        output in_valid, a, b, mode, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, acc_cnt
    );

    modport slave (
        input  in_valid, a, b, mode, acc_clr, out_ready,
        output in_ready, out_valid, out_data, out_ovf, acc_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_acc_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_acc_adder
//  Purpose  : Registered adder/accumulator with valid/ready on both sides and
//             wrap or saturate arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_acc_adder #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int SAT   = 0,
    parameter int CNT_W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pipe_acc_adder_if.slave   bus
);

    localparam int               c_SUM_W    = OUT_W + 1;
    localparam logic [OUT_W-1:0] c_ALL_ONES = '1;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    generate
        if (OUT_W < IN_W + 1) begin : g_bad_width
            $error("pipe_acc_adder: OUT_W must be at least IN_W+1");
        end
    endgenerate

    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_ovf;
    logic [OUT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_acc_cnt;

    logic               w_in_ready;
    logic               w_accept;
    logic [OUT_W-1:0]   w_acc_eff;
    logic [c_SUM_W-1:0] w_sum;
    logic               w_ovf;
    logic [OUT_W-1:0]   w_result;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // A clear in the same cycle as an accumulate beat restarts from zero.
    assign w_acc_eff = bus.acc_clr ? '0 : r_acc;
    assign w_sum     = (bus.mode ? c_SUM_W'(w_acc_eff) : '0)
                     + c_SUM_W'(bus.a) + c_SUM_W'(bus.b);
    assign w_ovf     = w_sum[OUT_W];
    assign w_result  = ((SAT != 0) && w_ovf) ? c_ALL_ONES : w_sum[OUT_W-1:0];
    assign w_cnt_inc = (r_acc_cnt == c_CNT_MAX) ? r_acc_cnt : r_acc_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_ovf   <= w_ovf;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else if (w_accept && bus.mode) begin
            r_acc     <= w_result;
            r_acc_cnt <= bus.acc_clr ? CNT_W'(1) : w_cnt_inc;
        end else if (bus.acc_clr) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.acc_cnt   = r_acc_cnt;

endmodule
`default_nettype wire
